// File: rtl/serial_receiver.sv
// -----------------------------------------------------------------------------
// serial_receiver
//   Receiving end of the one-wire serial link. The line idles low. A frame is
//   one start bit (1) followed by DATA_W data bits, MSB first, one bit per clk.
//   The sender drives on negedge, so every posedge samples mid-bit. The
//   rebuilt word is presented with a one-cycle valid pulse. A line held high
//   for too long after a frame raises line_err until the line returns low.
//
// Parameters
//   DATA_W        payload bits per frame (start bit excluded)
//   GAP_TIMEOUT   high samples tolerated in GAP before line_err is raised
//
// Ports
//   clk             in   1       single clock, sin sampled on posedge
//   rst             in   1       asynchronous, active-high reset
//   sin             in   1       serial input, same clock domain as sender
//   out_data        out  DATA_W  last completed word, MSB = first data bit
//   out_data_valid  out  1       one-cycle pulse when out_data is updated
//   busy            out  1       high while a frame is being received
//   line_err        out  1       sin stuck high in GAP; cleared on next low
// -----------------------------------------------------------------------------
module serial_receiver #(
    parameter int DATA_W      = 40,
    parameter int GAP_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sin,
    output logic [DATA_W-1:0] out_data,
    output logic              out_data_valid,
    output logic              busy,
    output logic              line_err
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam int GAP_W = $clog2(GAP_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [DATA_W-1:0] r_shreg;
    logic [DATA_W-1:0] r_out_data;
    logic              r_valid;
    logic              r_busy;
    logic              r_line_err;

    logic              w_last_bit;
    logic [DATA_W-1:0] w_word;

    // The word including the bit being sampled right now; on the final data
    // bit this is the complete frame.
    assign w_word     = {r_shreg[DATA_W-2:0], sin};
    assign w_last_bit = (r_state == RECV) && (r_cnt == CNT_W'(DATA_W - 1));

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: next state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (sin) w_next_state = RECV;
            RECV:    if (w_last_bit) w_next_state = GAP;
            // A high sample here is never a start bit: at least one low bit
            // must separate frames.
            GAP:     if (!sin) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_gap_cnt  <= '0;
            r_shreg    <= '0;
            r_out_data <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_line_err <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_busy  <= (w_next_state == RECV);
            case (r_state)
                IDLE: begin
                    // The start sample itself is not stored.
                    if (sin) begin
                        r_cnt <= '0;
                    end
                end
                RECV: begin
                    r_shreg <= w_word;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last_bit) begin
                        r_out_data <= w_word;
                        r_valid    <= 1'b1;
                        r_gap_cnt  <= '0;
                    end
                end
                GAP: begin
                    if (!sin) begin
                        r_line_err <= 1'b0;
                    end else if (r_gap_cnt != GAP_W'(GAP_TIMEOUT)) begin
                        // Counter saturates at GAP_TIMEOUT; the error is raised
                        // on the same edge the count reaches it.
                        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                        if (r_gap_cnt == GAP_W'(GAP_TIMEOUT - 1)) begin
                            r_line_err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_data       = r_out_data;
    assign out_data_valid = r_valid;
    assign busy           = r_busy;
    assign line_err       = r_line_err;

endmodule

// File: tb/tb_serial_receiver.sv
// -----------------------------------------------------------------------------
// tb_serial_receiver
//   Self-checking bench for serial_receiver (DATA_W=40, GAP_TIMEOUT=64).
//   sin is driven on negedge, outputs are observed 1ns after posedge. The
//   random test builds the whole bit stream up front together with the
//   expected valid/busy pattern derived from frame positions.
// -----------------------------------------------------------------------------
module tb_serial_receiver;

    localparam int DW  = 40;
    localparam int GTO = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sin = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_data_valid;
    logic          busy;
    logic          line_err;

    int total = 0;
    int bad   = 0;

    // Word out_data is expected to hold between frames.
    logic [DW-1:0] model_word = '0;

    serial_receiver #(.DATA_W(DW), .GAP_TIMEOUT(GTO)) dut (
        .clk            (clk),
        .rst            (rst),
        .sin            (sin),
        .out_data       (out_data),
        .out_data_valid (out_data_valid),
        .busy           (busy),
        .line_err       (line_err)
    );

    always #5 clk = ~clk;

    // Drive one bit on negedge, then observe just after the following posedge.
    task automatic tick(input logic b);
        @(negedge clk);
        sin = b;
        @(posedge clk);
        #1;
    endtask

    // Drive start bit plus DW data bits (MSB first) and record what was seen
    // over those DW+1 edges. Sample index 0 is the start-bit edge.
    task automatic send_frame(input logic [DW-1:0] w, output int n_valid,
                              output int busy_cyc, output int valid_at,
                              output logic [DW-1:0] data_seen);
        n_valid   = 0;
        busy_cyc  = 0;
        valid_at  = -1;
        data_seen = '0;
        for (int i = 0; i <= DW; i++) begin
            tick(i == 0 ? 1'b1 : w[DW-i]);
            if (busy) busy_cyc++;
            if (out_data_valid) begin
                n_valid++;
                valid_at  = i;
                data_seen = out_data;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({out_data, out_data_valid, busy, line_err} !== '0) begin
            bad++;
            $display("FAIL reset_hold: got data=%h v=%b busy=%b err=%b, want all 0",
                     out_data, out_data_valid, busy, line_err);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1'b0);
            total++;
            if ({out_data, out_data_valid, busy, line_err} !== '0) begin
                bad++;
                $display("FAIL reset_idle[%0d]: got data=%h v=%b busy=%b err=%b, want all 0",
                         i, out_data, out_data_valid, busy, line_err);
            end
        end
        model_word = '0;
    endtask

    task automatic test_single_frame();
        int nv, bc, va;
        logic [DW-1:0] d;
        send_frame(40'hD999999991, nv, bc, va, d);
        total++;
        if (nv !== 1) begin
            bad++; $display("FAIL single_nvalid: got %0d want 1", nv);
        end
        total++;
        if (va !== DW) begin
            bad++; $display("FAIL single_latency: pulse at edge +%0d want +%0d", va, DW);
        end
        total++;
        if (d !== 40'hD999999991) begin
            bad++; $display("FAIL single_data: got %h want %h", d, 40'hD999999991);
        end
        total++;
        if (bc !== DW) begin
            bad++; $display("FAIL single_busy_len: got %0d want %0d", bc, DW);
        end
        tick(1'b0);
        total++;
        if (out_data_valid !== 1'b0 || busy !== 1'b0 || out_data !== 40'hD999999991) begin
            bad++;
            $display("FAIL single_after: got v=%b busy=%b data=%h want 0 0 %h",
                     out_data_valid, busy, out_data, 40'hD999999991);
        end
        model_word = 40'hD999999991;
    endtask

    task automatic test_back_to_back();
        int nv, bc, va;
        logic [DW-1:0] d;
        send_frame('0, nv, bc, va, d);
        total++;
        if (nv !== 1 || va !== DW || d !== '0) begin
            bad++;
            $display("FAIL b2b_first: got n=%0d at=%0d data=%h want 1 %0d 0", nv, va, d, DW);
        end
        tick(1'b0);
        send_frame('1, nv, bc, va, d);
        total++;
        if (nv !== 1 || va !== DW || d !== {DW{1'b1}}) begin
            bad++;
            $display("FAIL b2b_second: got n=%0d at=%0d data=%h want 1 %0d all-ones", nv, va, d, DW);
        end
        tick(1'b0);
        total++;
        if (busy !== 1'b0 || out_data_valid !== 1'b0 || line_err !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle: got busy=%b v=%b err=%b want 0 0 0",
                     busy, out_data_valid, line_err);
        end
        model_word = '1;
    endtask

    task automatic test_line_err();
        int nv, bc, va;
        int n_err_cyc;
        logic [DW-1:0] d;
        logic exp_err;
        send_frame(40'h8000000001, nv, bc, va, d);
        total++;
        if (nv !== 1 || d !== 40'h8000000001) begin
            bad++; $display("FAIL lerr_frame: got n=%0d data=%h want 1 %h", nv, d, 40'h8000000001);
        end
        n_err_cyc = 0;
        for (int j = 1; j <= 70; j++) begin
            tick(1'b1);
            exp_err = (j >= GTO);
            total++;
            if (line_err !== exp_err || busy !== 1'b0 || out_data_valid !== 1'b0) begin
                n_err_cyc++;
                bad++;
                if (n_err_cyc <= 5)
                    $display("FAIL lerr_hold[%0d]: got err=%b busy=%b v=%b want %b 0 0",
                             j, line_err, busy, out_data_valid, exp_err);
            end
        end
        tick(1'b0);
        total++;
        if (line_err !== 1'b0 || busy !== 1'b0 || out_data !== 40'h8000000001) begin
            bad++;
            $display("FAIL lerr_clear: got err=%b busy=%b data=%h want 0 0 %h",
                     line_err, busy, out_data, 40'h8000000001);
        end
        send_frame(40'h5A5A0FF0C3, nv, bc, va, d);
        total++;
        if (nv !== 1 || va !== DW || d !== 40'h5A5A0FF0C3 || line_err !== 1'b0) begin
            bad++;
            $display("FAIL lerr_next: got n=%0d at=%0d data=%h err=%b want 1 %0d %h 0",
                     nv, va, d, line_err, DW, 40'h5A5A0FF0C3);
        end
        tick(1'b0);
        model_word = 40'h5A5A0FF0C3;
    endtask

    task automatic test_reset_mid_frame();
        int nv, bc, va;
        int seen_valid;
        logic [DW-1:0] d;
        logic [DW-1:0] partial;
        partial    = 40'hFEDCBA9876;
        seen_valid = 0;
        tick(1'b1);
        for (int i = 0; i < 20; i++) begin
            tick(partial[DW-1-i]);
            if (out_data_valid) seen_valid++;
        end
        #2;
        rst = 1'b1;
        sin = 1'b0;
        #1;
        // Reset is asynchronous: outputs must clear before any clock edge.
        total++;
        if (out_data_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0 || seen_valid !== 0) begin
            bad++;
            $display("FAIL rst_mid: got v=%b busy=%b data=%h early_valids=%0d want 0 0 0 0",
                     out_data_valid, busy, out_data, seen_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        tick(1'b0);
        tick(1'b0);
        total++;
        if (out_data_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0) begin
            bad++;
            $display("FAIL rst_mid_after: got v=%b busy=%b data=%h want 0 0 0",
                     out_data_valid, busy, out_data);
        end
        send_frame(40'h123456789A, nv, bc, va, d);
        total++;
        if (nv !== 1 || va !== DW || d !== 40'h123456789A || bc !== DW) begin
            bad++;
            $display("FAIL rst_resend: got n=%0d at=%0d data=%h busy=%0d want 1 %0d %h %0d",
                     nv, va, d, bc, DW, 40'h123456789A, DW);
        end
        tick(1'b0);
        model_word = 40'h123456789A;
    endtask

    task automatic test_random();
        logic          q_bit[$];
        logic          q_v[$];
        logic          q_b[$];
        logic [DW-1:0] q_word[$];
        logic [DW-1:0] w;
        logic [DW-1:0] cur;
        int            n_low;
        int            n_fail;
        int            n_pulse;
        // Build the stream: 1..3 low bits, start bit, DW data bits. The start
        // edge and first DW-1 data edges leave busy high; the last data edge
        // produces the valid pulse.
        for (int f = 0; f < 200; f++) begin
            w     = {$urandom(), $urandom()};
            n_low = $urandom_range(1, 3);
            for (int i = 0; i < n_low; i++) begin
                q_bit.push_back(1'b0); q_v.push_back(1'b0); q_b.push_back(1'b0);
            end
            q_bit.push_back(1'b1); q_v.push_back(1'b0); q_b.push_back(1'b1);
            for (int i = 0; i < DW; i++) begin
                q_bit.push_back(w[DW-1-i]);
                q_v.push_back(i == DW - 1);
                q_b.push_back(i != DW - 1);
            end
            q_word.push_back(w);
        end
        q_bit.push_back(1'b0); q_v.push_back(1'b0); q_b.push_back(1'b0);

        cur     = model_word;
        n_fail  = 0;
        n_pulse = 0;
        for (int e = 0; e < q_bit.size(); e++) begin
            tick(q_bit[e]);
            if (q_v[e]) begin
                cur = q_word.pop_front();
                n_pulse++;
            end
            total++;
            if (out_data_valid !== q_v[e] || busy !== q_b[e] ||
                out_data !== cur || line_err !== 1'b0) begin
                bad++;
                n_fail++;
                if (n_fail <= 5)
                    $display("FAIL random[%0d]: got v=%b busy=%b data=%h err=%b want %b %b %h 0",
                             e, out_data_valid, busy, out_data, line_err, q_v[e], q_b[e], cur);
            end
        end
        total++;
        if (n_pulse !== 200 || q_word.size() !== 0) begin
            bad++;
            $display("FAIL random_count: got pulses=%0d left=%0d want 200 0", n_pulse, q_word.size());
        end
        model_word = cur;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_line_err();
        test_reset_mid_frame();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
